ysyx_22041207_if_prefetch: RTL

- Parametrised successor to the single-request instruction fetch stage.
- Sits between the PC-redirect sources (MEM-stage branch/jump resolution, CSR trap) and the decode stage. Uses the codebase's rx_* AXI-style read handshake on a 64-bit bus.
- Keeps up to MAX_OUTSTANDING fetch reads in flight and buffers returned instructions in a FIFO_DEPTH-entry queue.
- Presents instructions to decode with a valid/ready handshake. On redirect it flushes the queue and discards stale responses in flight.

---
 rtl/ysyx_22041207_if_prefetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_if_prefetch.sv
// Instruction prefetch stage: several fetch reads in flight, an instruction queue
// toward decode, and a flush that discards stale responses after a redirect or trap.
module ysyx_22041207_if_prefetch #(
    parameter logic [63:0] RESET_PC        = 64'h8000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [63:0] trap_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        rx_r_valid_i,
    input  logic        rx_r_ready_o,
    output logic [63:0] rx_r_addr_i,
    output logic [7:0]  rx_r_size_i,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    input  logic [63:0] rx_data_read_o
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = CW + OW;

    logic [63:0]   fetch_pc;
    logic          pend_stale;
    logic [63:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [63:0]   inf_addr  [MAX_OUTSTANDING];
    logic [IW-1:0] inf_rd, inf_wr;
    logic [OW-1:0] live, drop;

    logic          addr_hs, data_hs, flush, keep, push, pop, hold_req, req_n;
    logic [63:0]   target, fetch_pc_n, head_addr;
    logic [31:0]   word;
    logic [OW-1:0] live_n, drop_n;
    logic [CW-1:0] count_n;
    logic [SW-1:0] fill_n, out_n;

    function automatic logic [IW-1:0] inf_next(input logic [IW-1:0] p);
        return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + IW'(1);
    endfunction

    assign rx_r_size_i   = 8'b0000_1111;
    assign rx_data_ready = (live != '0) || (drop != '0);
    assign out_valid     = fifo_count != '0;
    assign inst_o        = out_valid ? fifo_inst[rd_ptr] : '0;
    assign pc_o          = out_valid ? fifo_pc[rd_ptr] : '0;

    assign addr_hs   = rx_r_valid_i && rx_r_ready_o;
    assign data_hs   = rx_data_valid && rx_data_ready;
    assign flush     = redirect_valid || trap_valid;
    assign target    = redirect_valid ? redirect_pc : trap_vec;
    assign head_addr = inf_addr[inf_rd];
    assign word      = head_addr[2] ? rx_data_read_o[63:32] : rx_data_read_o[31:0];
    assign keep      = data_hs && (drop == '0);
    assign push      = keep && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign hold_req  = rx_r_valid_i && !rx_r_ready_o;

    // Next-state counters; the issue decision uses them so a raised request
    // always has credit in the cycle it is visible.
    always_comb begin
        live_n     = live;
        drop_n     = drop;
        count_n    = fifo_count;
        fetch_pc_n = fetch_pc;
        if (flush) begin
            drop_n     = live + drop + OW'(addr_hs) - OW'(data_hs);
            live_n     = '0;
            count_n    = '0;
            fetch_pc_n = target;
        end else begin
            // A request raised before a redirect completes at its old address
            // and must neither count as live nor advance fetch_pc.
            if (addr_hs && !pend_stale) begin
                live_n     = live_n + OW'(1);
                fetch_pc_n = fetch_pc + 64'd4;
            end
            if (addr_hs && pend_stale)     drop_n = drop_n + OW'(1);
            if (data_hs && drop != '0)     drop_n = drop_n - OW'(1);
            if (keep)                      live_n = live_n - OW'(1);
            count_n = fifo_count + CW'(push) - CW'(pop);
        end
        fill_n = SW'(count_n) + SW'(live_n);
        out_n  = SW'(live_n) + SW'(drop_n);
        req_n  = hold_req || ((fill_n < SW'(FIFO_DEPTH)) && (out_n < SW'(MAX_OUTSTANDING)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            pend_stale   <= 1'b0;
            rx_r_valid_i <= 1'b0;
            rx_r_addr_i  <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            inf_rd       <= '0;
            inf_wr       <= '0;
            live         <= '0;
            drop         <= '0;
        end else begin
            fetch_pc     <= fetch_pc_n;
            live         <= live_n;
            drop         <= drop_n;
            fifo_count   <= count_n;
            rx_r_valid_i <= req_n;
            rx_r_addr_i  <= hold_req ? rx_r_addr_i : fetch_pc_n;
            pend_stale   <= hold_req && (pend_stale || flush);
            if (addr_hs) inf_wr <= inf_next(inf_wr);
            if (data_hs) inf_rd <= inf_next(inf_rd);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + FW'(1);
                if (pop)  rd_ptr <= rd_ptr + FW'(1);
            end
        end
    end

    // Storage needs no reset: empty entries are masked on the outputs.
    always_ff @(posedge clk) begin
        if (!rst && addr_hs) inf_addr[inf_wr] <= rx_r_addr_i;
        if (!rst && push) begin
            fifo_pc[wr_ptr]   <= head_addr;
            fifo_inst[wr_ptr] <= word;
        end
    end
endmodule
